// File: rtl/display_pkg.sv
// Shared 7-segment display definitions: segment bit order and active-high glyph constants.
// Glyphs use bit0=a ... bit6=g ordering.
package display_pkg;

    typedef logic [6:0] glyph_t;

    typedef enum int {
        SEG_A = 0,
        SEG_B = 1,
        SEG_C = 2,
        SEG_D = 3,
        SEG_E = 4,
        SEG_F = 5,
        SEG_G = 6
    } seg_bit_e;

    localparam glyph_t GLYPH_0    = 7'h3F;
    localparam glyph_t GLYPH_1    = 7'h06;
    localparam glyph_t GLYPH_2    = 7'h5B;
    localparam glyph_t GLYPH_3    = 7'h4F;
    localparam glyph_t GLYPH_4    = 7'h66;
    localparam glyph_t GLYPH_5    = 7'h6D;
    localparam glyph_t GLYPH_6    = 7'h7D;
    localparam glyph_t GLYPH_7    = 7'h07;
    localparam glyph_t GLYPH_8    = 7'h7F;
    localparam glyph_t GLYPH_9    = 7'h6F;
    localparam glyph_t GLYPH_A    = 7'h77;
    localparam glyph_t GLYPH_B    = 7'h7C;
    localparam glyph_t GLYPH_C    = 7'h39;
    localparam glyph_t GLYPH_D    = 7'h5E;
    localparam glyph_t GLYPH_E    = 7'h79;
    localparam glyph_t GLYPH_F    = 7'h71;
    localparam glyph_t GLYPH_DASH = 7'h40;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit value to active-high 7-segment glyph.
// With i_hex_mode low, values 10..15 render as a dash.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] i_value,
    input  logic       i_hex_mode,
    output glyph_t     o_glyph
);

    always_comb begin
        o_glyph = GLYPH_DASH;
        case (i_value)
            4'h0: o_glyph = GLYPH_0;
            4'h1: o_glyph = GLYPH_1;
            4'h2: o_glyph = GLYPH_2;
            4'h3: o_glyph = GLYPH_3;
            4'h4: o_glyph = GLYPH_4;
            4'h5: o_glyph = GLYPH_5;
            4'h6: o_glyph = GLYPH_6;
            4'h7: o_glyph = GLYPH_7;
            4'h8: o_glyph = GLYPH_8;
            4'h9: o_glyph = GLYPH_9;
            4'hA: o_glyph = i_hex_mode ? GLYPH_A : GLYPH_DASH;
            4'hB: o_glyph = i_hex_mode ? GLYPH_B : GLYPH_DASH;
            4'hC: o_glyph = i_hex_mode ? GLYPH_C : GLYPH_DASH;
            4'hD: o_glyph = i_hex_mode ? GLYPH_D : GLYPH_DASH;
            4'hE: o_glyph = i_hex_mode ? GLYPH_E : GLYPH_DASH;
            4'hF: o_glyph = i_hex_mode ? GLYPH_F : GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Multiplexed 7-segment driver: double-buffered digit load, prescaled digit scan,
// leading-zero blanking and an all-off gap at the start of each digit slot.
module bcd_scan_display
    import display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 12500,
    parameter int BLANK_CYCLES   = 250,
    parameter bit HEX_MODE       = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lzb_en,
    input  logic                    load,
    output logic                    pending,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam glyph_t                SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;

    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_W-1:0]     r_shadow_data;
    logic [NUM_DIGITS-1:0] r_shadow_dp;
    logic [DATA_W-1:0]     r_active_data;
    logic [NUM_DIGITS-1:0] r_active_dp;
    logic                  r_pending;
    logic                  r_frame_start;
    logic [NUM_DIGITS-1:0] r_an;
    glyph_t                r_seg;
    logic                  r_dp;

    logic                  w_slot_end;
    logic                  w_commit;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_blank;
    logic [NUM_DIGITS-1:0] w_an_onehot;
    logic [3:0]            w_digit_val;
    glyph_t                w_glyph;

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_commit    = w_slot_end && (r_idx == IDX_LAST);
    assign w_digit_val = r_active_data[{r_idx, 2'b00} +: 4];

    generate
        if (BLANK_CYCLES == 0) begin : g_no_gap
            assign w_lit = 1'b1;
        end else begin : g_gap
            assign w_lit = (r_cnt >= CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    // A digit above 0 is blanked only when it and every more significant digit are zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_an_onehot[gi] = (r_idx == IDX_W'(gi));
            if (gi == 0) begin : g_lsd
                assign w_blank[gi] = 1'b0;
            end else begin : g_upper
                assign w_blank[gi] = lzb_en && (r_active_data[DATA_W-1:4*gi] == '0);
            end
        end
    endgenerate

    seg7_decoder u_decoder (
        .i_value    (w_digit_val),
        .i_hex_mode (HEX_MODE),
        .o_glyph    (w_glyph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
            r_active_data <= '0;
            r_active_dp   <= '0;
            r_pending     <= 1'b0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
            if (w_slot_end) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            // A load on the commit edge still commits the old shadow; the new data waits a frame.
            if (w_commit && r_pending) begin
                r_active_data <= r_shadow_data;
                r_active_dp   <= r_shadow_dp;
            end
            if (load) begin
                r_shadow_data <= data_in;
                r_shadow_dp   <= dp_in;
                r_pending     <= 1'b1;
            end else if (w_commit) begin
                r_pending     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_start <= 1'b0;
            r_an          <= AN_OFF;
            r_seg         <= SEG_OFF;
            r_dp          <= DP_OFF;
        end else begin
            r_frame_start <= w_commit;
            r_an          <= w_lit ? (w_an_onehot ^ AN_OFF) : AN_OFF;
            r_seg         <= (w_lit && !w_blank[r_idx]) ? (w_glyph ^ SEG_OFF) : SEG_OFF;
            r_dp          <= (w_lit && r_active_dp[r_idx]) ^ DP_OFF;
        end
    end

    assign pending     = r_pending;
    assign frame_start = r_frame_start;
    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = r_dp;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display (4 digits, 8-cycle slots, 2-cycle gap, active-low),
// with a decimal-mode and a hex-mode instance driven from the same inputs.
module tb_bcd_scan_display;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic        lzb_en = 1'b0;
    logic        load = 1'b0;

    logic       pending, frame_start, dp;
    logic [3:0] an;
    logic [6:0] seg;
    logic       h_pending, h_frame_start, h_dp;
    logic [3:0] h_an;
    logic [6:0] h_seg;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q_dec[$];
    exp_t q_hex[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bcd_scan_display #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .HEX_MODE(1'b0),
                       .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .lzb_en(lzb_en),
        .load(load), .pending(pending), .frame_start(frame_start), .an(an), .seg(seg), .dp(dp)
    );

    bcd_scan_display #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .HEX_MODE(1'b1),
                       .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_hex (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .lzb_en(lzb_en),
        .load(load), .pending(h_pending), .frame_start(h_frame_start), .an(h_an), .seg(h_seg),
        .dp(h_dp)
    );

    function automatic logic [6:0] ref_glyph(input logic [3:0] v, input bit hex);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return hex ? 7'h77 : 7'h40;
            4'hB: return hex ? 7'h7C : 7'h40;
            4'hC: return hex ? 7'h39 : 7'h40;
            4'hD: return hex ? 7'h5E : 7'h40;
            4'hE: return hex ? 7'h79 : 7'h40;
            default: return hex ? 7'h71 : 7'h40;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Expected per-digit outputs (active-low) for one frame showing d/p.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] p, input bit lzb);
        exp_t e;
        bit   blank;
        for (int i = 0; i < ND; i++) begin
            blank = lzb && (i > 0) && ((d >> (4 * i)) == 16'h0);
            e.an  = ~(4'b0001 << i);
            e.dp  = ~p[i];
            e.seg = blank ? 7'h7F : ~ref_glyph(d[4*i +: 4], 1'b0);
            q_dec.push_back(e);
            e.seg = blank ? 7'h7F : ~ref_glyph(d[4*i +: 4], 1'b1);
            q_hex.push_back(e);
        end
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 2 * FRAME);
        chk({tag, "_frame_start"}, frame_start, 1'b1);
        chk({tag, "_hex_frame_start"}, h_frame_start, 1'b1);
    endtask

    // Called at the negedge of a frame_start cycle; checks the gap and each digit's lit window.
    task automatic scan_frame(input string tag);
        exp_t e;
        int   d;
        for (int c = 1; c < FRAME; c++) begin
            @(negedge clk);
            d = c / SD;
            if (c % SD == 1) begin
                chk($sformatf("%s_d%0d_gap_an", tag, d), an, 4'hF);
                chk($sformatf("%s_d%0d_gap_seg", tag, d), seg, 7'h7F);
                chk($sformatf("%s_d%0d_gap_dp", tag, d), dp, 1'b1);
            end
            if (c % SD == 5) begin
                e = q_dec.pop_front();
                chk($sformatf("%s_d%0d_an", tag, d), an, e.an);
                chk($sformatf("%s_d%0d_seg", tag, d), seg, e.seg);
                chk($sformatf("%s_d%0d_dp", tag, d), dp, e.dp);
                e = q_hex.pop_front();
                chk($sformatf("%s_d%0d_hex_an", tag, d), h_an, e.an);
                chk($sformatf("%s_d%0d_hex_seg", tag, d), h_seg, e.seg);
                chk($sformatf("%s_d%0d_hex_dp", tag, d), h_dp, e.dp);
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic exp_pending);
        wait_fs(tag);
        chk({tag, "_pending"}, pending, exp_pending);
        scan_frame(tag);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input int gap);
        repeat (gap) @(negedge clk);
        data_in = d;
        dp_in   = p;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk($sformatf("load_%h_pending", d), pending, 1'b1);
    endtask

    task automatic check_restart(input string tag);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c <= BC || c == 9) begin
                chk($sformatf("%s_c%0d_an_off", tag, c), an, 4'hF);
                chk($sformatf("%s_c%0d_seg_off", tag, c), seg, 7'h7F);
            end else begin
                chk($sformatf("%s_c%0d_an_d0", tag, c), an, 4'hE);
                chk($sformatf("%s_c%0d_seg_zero", tag, c), seg, 7'h40);
            end
        end
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_pending", pending, 1'b0);
        chk("rst_frame_start", frame_start, 1'b0);

        // Release with no load: gap, digit 0 showing 0, first frame_start 32 cycles in
        rst_n = 1'b1;
        check_restart("idle");
        for (int c = 10; c <= FRAME; c++) begin
            @(negedge clk);
            if (c == FRAME - 1) chk("idle_fs_low", frame_start, 1'b0);
            if (c == FRAME) chk("idle_fs_first", frame_start, 1'b1);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 2 * FRAME);
        chk("frame_period", n, FRAME);
        push_frame(16'h0000, 4'b0000, 1'b0);
        scan_frame("idle");

        // Mid-frame load
        do_load(16'h1234, 4'b0100, 10);
        push_frame(16'h1234, 4'b0100, 1'b0);
        check_frame("f1234", 1'b0);

        // Leading-zero blanking
        lzb_en = 1'b1;
        do_load(16'h0005, 4'b0000, 3);
        push_frame(16'h0005, 4'b0000, 1'b1);
        check_frame("lzb0005", 1'b0);
        do_load(16'h0000, 4'b0000, 3);
        push_frame(16'h0000, 4'b0000, 1'b1);
        check_frame("lzb0000", 1'b0);
        lzb_en = 1'b0;

        // Out-of-range digits: dash vs hex letters
        do_load(16'h00AF, 4'b0000, 3);
        push_frame(16'h00AF, 4'b0000, 1'b0);
        check_frame("f00AF", 1'b0);

        // Last load wins before commit
        do_load(16'h1111, 4'b0000, 3);
        do_load(16'h2222, 4'b0000, 2);
        push_frame(16'h2222, 4'b0000, 1'b0);
        check_frame("last_wins", 1'b0);

        // Load exactly on the commit edge: scan_frame returned in the commit-state cycle
        data_in = 16'h3333;
        dp_in   = 4'b0000;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("commit_edge_fs", frame_start, 1'b1);
        chk("commit_edge_pending_held", pending, 1'b1);
        push_frame(16'h2222, 4'b0000, 1'b0);
        scan_frame("held2222");
        push_frame(16'h3333, 4'b0000, 1'b0);
        check_frame("late3333", 1'b0);

        // Asynchronous reset in digit 2's lit window
        do_load(16'h9876, 4'b1111, 0);
        repeat (19) @(negedge clk);
        chk("pre_rst_an_d2", an, 4'b1011);
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", an, 4'hF);
        chk("async_rst_seg", seg, 7'h7F);
        chk("async_rst_dp", dp, 1'b1);
        chk("async_rst_pending", pending, 1'b0);
        chk("async_rst_frame_start", frame_start, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_restart("post_rst");
        push_frame(16'h0000, 4'b0000, 1'b0);
        check_frame("post_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
